riscv_bp_gshare: RTL and testbench

Parametrised gshare conditional-branch predictor: table of CNT_BITS saturating counters indexed by PC XOR an internally maintained global history register (GHR).
- Sits between IF (read side) and the branch unit in EX (write side).
- GHR is updated speculatively on predicted branches and repaired on mispredict.
- After reset, a self-initialisation FSM clears the table before predictions are valid.

---
 rtl/riscv_bp_pkg.sv | 24 ++
 rtl/rl_ram_1r1w.sv | 25 ++
 rtl/riscv_bp_gshare.sv | 149 ++++++++++++++
 tb/tb_riscv_bp_gshare.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/riscv_bp_pkg.sv
// Shared types and counter helpers for the gshare branch predictor.
package riscv_bp_pkg;

    typedef enum logic {
        INIT,
        RUN
    } bp_state_e;

    // Weakly-not-taken: the largest value whose MSB is still clear.
    function automatic logic [3:0] wnt(input int cnt_bits);
        return 4'((1 << (cnt_bits - 1)) - 1);
    endfunction

    function automatic logic [3:0] sat_update(input logic [3:0] cnt, input logic taken,
                                              input int cnt_bits);
        logic [3:0] max_val;
        max_val = 4'((1 << cnt_bits) - 1);
        if (taken)
            return (cnt >= max_val) ? max_val : cnt + 4'd1;
        else
            return (cnt == 4'd0) ? 4'd0 : cnt - 4'd1;
    endfunction

endpackage

// File: rtl/rl_ram_1r1w.sv
// Simple dual-port RAM: one synchronous read port, one write port, read-before-write.
module rl_ram_1r1w #(
    parameter int ABITS = 10,
    parameter int DBITS = 2
) (
    input  logic             clk,
    input  logic [ABITS-1:0] raddr,
    input  logic             re,
    output logic [DBITS-1:0] rdata,
    input  logic [ABITS-1:0] waddr,
    input  logic             we,
    input  logic             be,
    input  logic [DBITS-1:0] wdata
);

    logic [DBITS-1:0] mem [2**ABITS];

    always_ff @(posedge clk) begin
        if (re)
            rdata <= mem[raddr];
        if (we && be)
            mem[waddr] <= wdata;
    end

endmodule

// File: rtl/riscv_bp_gshare.sv
// Gshare conditional-branch predictor: PC XOR global history indexes a table of
// saturating counters; a self-initialisation pass clears the table after reset.
module riscv_bp_gshare
    import riscv_bp_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] PC_INIT  = 'h200,
    parameter int              GHR_BITS = 8,
    parameter int              IDX_BITS = 10,
    parameter int              IDX_LSB  = 2,
    parameter int              CNT_BITS = 2
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                id_stall_i,
    input  logic [XLEN-1:0]     if_parcel_pc_i,
    input  logic                if_branch_i,
    output logic [CNT_BITS-1:0] bp_predict_o,
    output logic                bp_taken_o,
    output logic [GHR_BITS-1:0] bp_history_o,
    output logic                bp_ready_o,
    input  logic [XLEN-1:0]     ex_pc_i,
    input  logic [GHR_BITS-1:0] bu_bp_history_i,
    input  logic [CNT_BITS-1:0] bu_bp_predict_i,
    input  logic                bu_bp_btaken_i,
    input  logic                bu_bp_update_i,
    input  logic                bu_bp_mispredict_i
);

    localparam int                  DEPTH = 2 ** IDX_BITS;
    localparam logic [CNT_BITS-1:0] WNT   = CNT_BITS'(wnt(CNT_BITS));

    bp_state_e           state;
    logic [IDX_BITS-1:0] init_cnt;
    logic [GHR_BITS-1:0] ghr;
    logic [GHR_BITS-1:0] hist;
    logic [XLEN-1:0]     pc_dly;
    logic                rd_in_init;

    logic [GHR_BITS-1:0] rd_hist;
    logic [IDX_BITS-1:0] rd_hist_ext;
    logic [IDX_BITS-1:0] rd_idx;
    logic [CNT_BITS-1:0] rd_data;
    logic [IDX_BITS-1:0] bu_hist_ext;
    logic [3:0]          cnt_ext;
    logic [3:0]          cnt_upd;
    logic                we;
    logic [IDX_BITS-1:0] waddr;
    logic [CNT_BITS-1:0] wdata;
    logic [GHR_BITS:0]   mis_shift;
    logic [GHR_BITS:0]   spec_shift;
    logic                unused;

    // While stalled the read re-uses the held PC and history so the outputs stay put.
    always_comb begin
        rd_hist     = id_stall_i ? hist : ghr;
        rd_hist_ext = '0;
        rd_hist_ext[GHR_BITS-1:0] = rd_hist;
        rd_idx = (id_stall_i ? pc_dly[IDX_LSB +: IDX_BITS] : if_parcel_pc_i[IDX_LSB +: IDX_BITS])
                 ^ rd_hist_ext;
    end

    always_comb begin
        bu_hist_ext = '0;
        bu_hist_ext[GHR_BITS-1:0] = bu_bp_history_i;
        cnt_ext = '0;
        cnt_ext[CNT_BITS-1:0] = bu_bp_predict_i;
        cnt_upd = sat_update(cnt_ext, bu_bp_btaken_i, CNT_BITS);
        if (state == INIT) begin
            we    = 1'b1;
            waddr = init_cnt;
            wdata = WNT;
        end else begin
            we    = bu_bp_update_i;
            waddr = ex_pc_i[IDX_LSB +: IDX_BITS] ^ bu_hist_ext;
            wdata = cnt_upd[CNT_BITS-1:0];
        end
    end

    rl_ram_1r1w #(
        .ABITS(IDX_BITS),
        .DBITS(CNT_BITS)
    ) u_table (
        .clk  (clk_i),
        .raddr(rd_idx),
        .re   (1'b1),
        .rdata(rd_data),
        .waddr(waddr),
        .we   (we),
        .be   (1'b1),
        .wdata(wdata)
    );

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state      <= INIT;
            init_cnt   <= '0;
            bp_ready_o <= 1'b0;
        end else begin
            case (state)
                INIT: begin
                    init_cnt <= init_cnt + 1'b1;
                    if (init_cnt == IDX_BITS'(DEPTH - 1)) begin
                        state      <= RUN;
                        bp_ready_o <= 1'b1;
                    end
                end
                default: state <= RUN;
            endcase
        end
    end

    assign mis_shift  = {bu_bp_history_i, bu_bp_btaken_i};
    assign spec_shift = {ghr, bp_taken_o};

    // A mispredict repair discards any speculative shift in the same cycle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni)
            ghr <= '0;
        else if (state == RUN) begin
            if (bu_bp_mispredict_i)
                ghr <= mis_shift[GHR_BITS-1:0];
            else if (if_branch_i && !id_stall_i)
                ghr <= spec_shift[GHR_BITS-1:0];
        end
    end

    // Reads issued during INIT may race the clearing writes, so their data is replaced by WNT.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pc_dly     <= PC_INIT;
            hist       <= '0;
            rd_in_init <= 1'b1;
        end else begin
            if (!id_stall_i)
                pc_dly <= if_parcel_pc_i;
            hist       <= rd_hist;
            rd_in_init <= (state == INIT);
        end
    end

    assign bp_predict_o = rd_in_init ? WNT : rd_data;
    assign bp_taken_o   = bp_predict_o[CNT_BITS-1];
    assign bp_history_o = hist;

    assign unused = ^{if_parcel_pc_i, ex_pc_i, pc_dly, cnt_upd, mis_shift[GHR_BITS],
                      spec_shift[GHR_BITS]};

endmodule

// File: tb/tb_riscv_bp_gshare.sv
// Scoreboard bench for riscv_bp_gshare: a behavioural model predicts every cycle's outputs.
module tb_riscv_bp_gshare;

    localparam int XLEN     = 32;
    localparam int GHR_BITS = 4;
    localparam int IDX_BITS = 4;
    localparam int IDX_LSB  = 2;
    localparam int CNT_BITS = 2;
    localparam int DEPTH    = 16;
    localparam int WNT      = 1;
    localparam int CMAX     = 3;

    logic                clk;
    logic                rst_n;
    logic                id_stall;
    logic [XLEN-1:0]     if_pc;
    logic                if_branch;
    logic [CNT_BITS-1:0] bp_predict;
    logic                bp_taken;
    logic [GHR_BITS-1:0] bp_history;
    logic                bp_ready;
    logic [XLEN-1:0]     ex_pc;
    logic [GHR_BITS-1:0] bu_history;
    logic [CNT_BITS-1:0] bu_predict;
    logic                bu_btaken;
    logic                bu_update;
    logic                bu_mispredict;

    riscv_bp_gshare #(
        .XLEN    (XLEN),
        .PC_INIT (32'h200),
        .GHR_BITS(GHR_BITS),
        .IDX_BITS(IDX_BITS),
        .IDX_LSB (IDX_LSB),
        .CNT_BITS(CNT_BITS)
    ) dut (
        .clk_i             (clk),
        .rst_ni            (rst_n),
        .id_stall_i        (id_stall),
        .if_parcel_pc_i    (if_pc),
        .if_branch_i       (if_branch),
        .bp_predict_o      (bp_predict),
        .bp_taken_o        (bp_taken),
        .bp_history_o      (bp_history),
        .bp_ready_o        (bp_ready),
        .ex_pc_i           (ex_pc),
        .bu_bp_history_i   (bu_history),
        .bu_bp_predict_i   (bu_predict),
        .bu_bp_btaken_i    (bu_btaken),
        .bu_bp_update_i    (bu_update),
        .bu_bp_mispredict_i(bu_mispredict)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int ready;
        int pred;
        int hist;
    } exp_t;

    exp_t sb_q[$];
    int   vectors;
    int   miscompares;

    int          m_tbl[DEPTH];
    int          m_ready;
    int          m_init;
    int          m_ghr;
    int          m_hist;
    int          m_pred;
    logic [31:0] m_pcdly;

    function automatic int pc_index(input logic [31:0] pc);
        return int'((pc >> IDX_LSB) % DEPTH);
    endfunction

    // One cycle: drive inputs at the falling edge and predict the outputs after the next rise.
    task automatic apply_stimulus(input bit rst, input bit stall, input logic [31:0] pc,
                                  input bit branch, input logic [31:0] expc, input int bhist,
                                  input int bpred, input bit btaken, input bit upd,
                                  input bit mis);
        int   rd_h;
        int   new_pred;
        int   cur_taken;
        logic [31:0] rd_pc;
        @(negedge clk);
        rst_n         = !rst;
        id_stall      = stall;
        if_pc         = pc;
        if_branch     = branch;
        ex_pc         = expc;
        bu_history    = GHR_BITS'(bhist);
        bu_predict    = CNT_BITS'(bpred);
        bu_btaken     = btaken;
        bu_update     = upd;
        bu_mispredict = mis;
        if (rst) begin
            m_ready = 0;
            m_init  = 0;
            m_ghr   = 0;
            m_hist  = 0;
            m_pred  = WNT;
            m_pcdly = 32'h200;
        end else begin
            cur_taken = m_pred / 2;
            rd_pc     = stall ? m_pcdly : pc;
            rd_h      = stall ? m_hist : m_ghr;
            new_pred  = m_ready ? m_tbl[pc_index(rd_pc) ^ rd_h] : WNT;
            if (m_ready) begin
                if (upd)
                    m_tbl[pc_index(expc) ^ bhist] = btaken ? ((bpred + 1 > CMAX) ? CMAX : bpred + 1)
                                                           : ((bpred == 0) ? 0 : bpred - 1);
                if (mis)
                    m_ghr = (bhist * 2 + int'(btaken)) % DEPTH;
                else if (branch && !stall)
                    m_ghr = (m_ghr * 2 + cur_taken) % DEPTH;
            end else begin
                m_init++;
                if (m_init == DEPTH) begin
                    m_ready = 1;
                    foreach (m_tbl[i]) m_tbl[i] = WNT;
                end
            end
            m_hist = rd_h;
            if (!stall) m_pcdly = pc;
            m_pred = new_pred;
        end
        sb_q.push_back('{ready: m_ready, pred: m_pred, hist: m_hist});
    endtask

    task automatic random_cycle(input int stall_pct);
        apply_stimulus(1'b0, ($urandom_range(99) < stall_pct), {$urandom_range(255), 2'b00} & 32'h3FC,
                       1'($urandom_range(1)), {$urandom_range(255), 2'b00} & 32'h3FC,
                       int'($urandom_range(15)), int'($urandom_range(3)), 1'($urandom_range(1)),
                       ($urandom_range(2) == 0), ($urandom_range(5) == 0));
    endtask

    task automatic idle_cycle(input logic [31:0] pc);
        apply_stimulus(1'b0, 1'b0, pc, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic check_output(input exp_t e);
        vectors++;
        if (int'(bp_ready) !== e.ready || int'(bp_predict) !== e.pred ||
            int'(bp_history) !== e.hist || int'(bp_taken) !== e.pred / 2) begin
            miscompares++;
            $display("[TB] FAIL cycle_outputs t=%0t: got ready=%0d predict=%0d taken=%0d history=%0d, expected ready=%0d predict=%0d taken=%0d history=%0d",
                     $time, bp_ready, bp_predict, bp_taken, bp_history,
                     e.ready, e.pred, e.pred / 2, e.hist);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                check_output(e);
            end
        end
    end

    initial begin : stimulus
        int wait_cycles;
        vectors       = 0;
        miscompares   = 0;
        rst_n         = 1'b0;
        id_stall      = 1'b0;
        if_pc         = '0;
        if_branch     = 1'b0;
        ex_pc         = '0;
        bu_history    = '0;
        bu_predict    = '0;
        bu_btaken     = 1'b0;
        bu_update     = 1'b0;
        bu_mispredict = 1'b0;
        foreach (m_tbl[i]) m_tbl[i] = WNT;

        repeat (3) apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        // Reset in the middle of INIT, then a full INIT pass with ignored updates.
        repeat (5) random_cycle(20);
        repeat (2) apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (DEPTH) random_cycle(20);
        for (int i = 0; i < DEPTH; i++) idle_cycle(32'(i * 4));

        // Saturation on entry 0 with history 0: four taken, five not-taken.
        for (int i = 0; i < 9; i++)
            apply_stimulus(1'b0, 1'b0, 32'h40, 1'b0, 32'h40, 0, m_tbl[0], (i < 4), 1'b1, 1'b0);
        repeat (2) idle_cycle(32'h40);

        // Make entry 1 strongly taken, then speculative shifts through it.
        repeat (2) apply_stimulus(1'b0, 1'b0, 32'h44, 1'b0, 32'h44, 0, m_tbl[1], 1'b1, 1'b1, 1'b0);
        idle_cycle(32'h44);
        repeat (3) apply_stimulus(1'b0, 1'b0, 32'h44, 1'b1, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle_cycle(32'h48);

        // Mispredict repair racing a speculative shift.
        apply_stimulus(1'b0, 1'b0, 32'h50, 1'b1, 32'h0, 5, 0, 1'b0, 1'b0, 1'b1);
        repeat (2) idle_cycle(32'h54);

        // Stall window with a changing PC and a history-changing mispredict.
        apply_stimulus(1'b0, 1'b1, 32'h60, 1'b1, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b1, 32'h64, 1'b1, 32'h0, 9, 0, 1'b1, 1'b0, 1'b1);
        apply_stimulus(1'b0, 1'b1, 32'h68, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (2) idle_cycle(32'h6C);

        repeat (400) random_cycle(25);

        apply_stimulus(1'b1, 1'b0, 32'h0, 1'b0, 32'h0, 0, 0, 1'b0, 1'b0, 1'b0);
        repeat (DEPTH + 40) random_cycle(25);

        wait_cycles = 0;
        while (sb_q.size() > 0 && wait_cycles < 10) begin
            @(posedge clk);
            wait_cycles++;
        end
        #2;
        if (sb_q.size() > 0) begin
            miscompares++;
            $display("[TB] FAIL drain: %0d entries left, expected 0", sb_q.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
